// File: rtl/mixed_opcode_tag_decoder.sv
// ---------------------------------------------------------------------------
// mixed_opcode_tag_decoder
//
// Purpose:
//   Consumer-side decoder for the mixed opcode path. A 9-bit opcode tag is
//   split back into a 3-bit opcode and a 6-bit offset within that opcode's
//   base. Decoding happens as the tag is written into a 2-entry skid FIFO.
//   The FIFO has valid/ready handshakes on both sides. Tags whose type field
//   is beyond TRIM are still delivered, but with op_err set.
//
//   A WAIT opcode with a non-zero offset throttles the output side. Once it
//   is popped, op_valid stays low for 'offset' cycles. The upstream side
//   keeps accepting tags during that time.
//
// Ports:
//   clk            in   block clock, rising edge
//   rst            in   synchronous active-high reset
//   tag_valid      in   upstream tag valid
//   tag_ready      out  upstream ready (FIFO holds fewer than 2 entries)
//   tag            in   encoded opcode tag (opcodeTagT, 9 bits)
//   op_valid       out  decoded entry valid
//   op_ready       in   downstream ready
//   op_code        out  decoded opcode (opcodeEnumT, 3 bits)
//   op_offset      out  6-bit offset within the opcode base
//   op_err         out  the tag was illegal
//   stat_clr       in   synchronous clear of the statistics counters
//   stat_illegal   out  saturating count of illegal tags accepted
//   stat_wait_cyc  out  saturating count of cycles spent holding after WAIT
//
// Configuration macro:
//   MIXED_OPCODE_DECODE_STATS_EN - builds the statistics counters. When the
//   macro is not defined, both stat outputs are tied to zero and stat_clr
//   is ignored.
// ---------------------------------------------------------------------------

package mixed_package;

  // Every opcode base is a multiple of 64: READ=0, WRITE=64, WAIT=128,
  // EVICT=192, TRIM=256. The top three tag bits therefore select the
  // opcode directly, and the low six bits carry the offset.
  typedef logic [8:0] opcodeTagT;

  typedef enum logic [2:0] {
    OPCODEATYPE_READ  = 3'd0,
    OPCODEATYPE_WRITE = 3'd1,
    OPCODEATYPE_WAIT  = 3'd2,
    OPCODEATYPE_EVICT = 3'd3,
    OPCODEATYPE_TRIM  = 3'd4
  } opcodeEnumT;

endpackage

module mixed_opcode_tag_decoder
  import mixed_package::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tag_valid,
  output logic        tag_ready,
  input  opcodeTagT   tag,
  output logic        op_valid,
  input  logic        op_ready,
  output opcodeEnumT  op_code,
  output logic [5:0]  op_offset,
  output logic        op_err,
  input  logic        stat_clr,
  output logic [15:0] stat_illegal,
  output logic [15:0] stat_wait_cyc
);

  // One FIFO entry: the decoded form of a tag.
  typedef struct packed {
    logic       err;
    opcodeEnumT code;
    logic [5:0] offset;
  } entryT;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_HOLD = 1'b1
  } stateT;

  entryT      decodedEntry;
  entryT      headEntry;
  entryT      fifoMem [2];
  logic       wrPtr;
  logic       rdPtr;
  logic [1:0] count;
  stateT      state;
  logic [5:0] holdCnt;
  logic       pushFire;
  logic       popFire;
  logic [2:0] tagTyp;

  // Tag decode on the write side of the FIFO. Type values 5..7 have no
  // opcode. Such tags still travel through the FIFO so the consumer sees
  // the error. Their opcode reads as READ and their offset is kept as-is.
  always_comb begin
    tagTyp              = tag[8:6];
    decodedEntry.offset = tag[5:0];
    decodedEntry.err    = 1'b0;
    decodedEntry.code   = OPCODEATYPE_READ;
    if (tagTyp > 3'd4) begin
      decodedEntry.err  = 1'b1;
      decodedEntry.code = OPCODEATYPE_READ;
    end else begin
      decodedEntry.err  = 1'b0;
      decodedEntry.code = opcodeEnumT'(tagTyp);
    end
  end

  // Handshake qualifiers.
  // tag_ready depends only on the registered count. This keeps op_ready out
  // of the upstream ready path, so a pop while full does not admit a push
  // in the same cycle.
  always_comb begin
    tag_ready = (count != 2'd2);
    op_valid  = (state == RUN) && (count != 2'd0);
    pushFire  = tag_valid && tag_ready;
    popFire   = op_valid && op_ready;
  end

  // The outputs look straight into the head slot. That slot is never
  // written while it holds a live entry: with one entry the write pointer
  // points at the other slot, and with two entries no push happens. The
  // fields therefore stay stable while the consumer stalls. When the FIFO
  // is empty they show whatever the head slot last held.
  always_comb begin
    headEntry = fifoMem[rdPtr];
    op_code   = headEntry.code;
    op_offset = headEntry.offset;
    op_err    = headEntry.err;
  end

  // FIFO storage, pointers and occupancy.
  // The memory is cleared on reset so the output fields come up as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifoMem[i] <= '0;
      end
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (pushFire) begin
        fifoMem[wrPtr] <= decodedEntry;
        wrPtr          <= ~wrPtr;
      end
      if (popFire) begin
        rdPtr <= ~rdPtr;
      end
      unique case ({pushFire, popFire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output throttle FSM.
  // Popping a legal WAIT with a non-zero offset parks the output for
  // 'offset' cycles. The counter is loaded on the popping edge and counts
  // down once per cycle in WAIT_HOLD. The edge that consumes the last count
  // returns the FSM to RUN. A WAIT with offset 0 is delivered like any other
  // opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      holdCnt <= 6'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (popFire && !headEntry.err &&
              (headEntry.code == OPCODEATYPE_WAIT) &&
              (headEntry.offset != 6'd0)) begin
            holdCnt <= headEntry.offset;
            state   <= WAIT_HOLD;
          end
        end
        WAIT_HOLD: begin
          holdCnt <= holdCnt - 6'd1;
          if (holdCnt == 6'd1) begin
            state <= RUN;
          end
        end
        default: begin
          state   <= RUN;
          holdCnt <= 6'd0;
        end
      endcase
    end
  end

`ifdef MIXED_OPCODE_DECODE_STATS_EN

  logic [15:0] illegalCnt;
  logic [15:0] waitCycCnt;

  // Statistics counters. Both counters saturate at all-ones. A clear takes
  // precedence over an increment in the same cycle. The illegal count is
  // taken at push time, because decoding happens on the write side.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegalCnt <= 16'd0;
      waitCycCnt <= 16'd0;
    end else if (stat_clr) begin
      illegalCnt <= 16'd0;
      waitCycCnt <= 16'd0;
    end else begin
      if (pushFire && decodedEntry.err && (illegalCnt != 16'hFFFF)) begin
        illegalCnt <= illegalCnt + 16'd1;
      end
      if ((state == WAIT_HOLD) && (waitCycCnt != 16'hFFFF)) begin
        waitCycCnt <= waitCycCnt + 16'd1;
      end
    end
  end

  assign stat_illegal  = illegalCnt;
  assign stat_wait_cyc = waitCycCnt;

`else

  // Without the counters, the clear input has nothing to act on.
  logic unusedStatClr;

  assign unusedStatClr = stat_clr;
  assign stat_illegal  = 16'd0;
  assign stat_wait_cyc = 16'd0;

`endif

endmodule

// File: tb/tb_mixed_opcode_tag_decoder.sv
// ---------------------------------------------------------------------------
// tb_mixed_opcode_tag_decoder
//
// Self-checking bench for mixed_opcode_tag_decoder. The reference model
// keeps the raw tags in a queue and decodes them arithmetically (tag / 64,
// tag % 64). A single integer counts the remaining hold cycles after a WAIT.
// Directed scenarios check fixed expected values. A randomized phase
// compares every cycle against the model.
// ---------------------------------------------------------------------------

module tb_mixed_opcode_tag_decoder;
  import mixed_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tagValid;
  logic        tagReady;
  opcodeTagT   tagIn;
  logic        opValid;
  logic        opReady;
  opcodeEnumT  opCode;
  logic [5:0]  opOffset;
  logic        opErr;
  logic        statClr;
  logic [15:0] statIllegal;
  logic [15:0] statWaitCyc;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state.
  opcodeTagT mq[$];
  int        mHold = 0;
  int        mIll  = 0;
  int        mWait = 0;

  mixed_opcode_tag_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .tag_valid     (tagValid),
    .tag_ready     (tagReady),
    .tag           (tagIn),
    .op_valid      (opValid),
    .op_ready      (opReady),
    .op_code       (opCode),
    .op_offset     (opOffset),
    .op_err        (opErr),
    .stat_clr      (statClr),
    .stat_illegal  (statIllegal),
    .stat_wait_cyc (statWaitCyc)
  );

  always #5 clk = ~clk;

  // A hard time bound in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit expValid();
    return (mHold == 0) && (mq.size() > 0);
  endfunction

  function automatic int expIll();
`ifdef MIXED_OPCODE_DECODE_STATS_EN
    return mIll;
`else
    return 0;
`endif
  endfunction

  function automatic int expWait();
`ifdef MIXED_OPCODE_DECODE_STATS_EN
    return mWait;
`else
    return 0;
`endif
  endfunction

  // Drive inputs right after the falling edge, then let them settle.
  task automatic applyStimulus(input bit tv, input opcodeTagT t, input bit ordy, input bit sc);
    tagValid = tv;
    tagIn    = t;
    opReady  = ordy;
    statClr  = sc;
    #1;
  endtask

  // Advance the model by one cycle using the currently driven inputs, then
  // move to the next falling edge.
  task automatic modelStep();
    bit        doPush;
    bit        doPop;
    opcodeTagT h;
    if (rst) begin
      mq.delete();
      mHold = 0;
      mIll  = 0;
      mWait = 0;
    end else begin
      doPush = tagValid && (mq.size() < 2);
      doPop  = expValid() && opReady;
      if (mHold > 0) begin
        if (mWait < 65535) mWait++;
        mHold--;
      end
      if (doPush && (int'(tagIn) >= 320) && (mIll < 65535)) mIll++;
      if (statClr) begin
        mIll  = 0;
        mWait = 0;
      end
      if (doPop) begin
        h = mq.pop_front();
        if ((int'(h) / 64 == 2) && (int'(h) % 64 != 0)) mHold = int'(h) % 64;
      end
      if (doPush) mq.push_back(tagIn);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
    modelStep();
    rst = 1'b0;
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    checkCount++;
    if (tagReady !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_tag_ready: got %b expected 1", tagReady); end
    checkCount++;
    if (opValid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_op_valid: got %b expected 0", opValid); end
    checkCount++;
    if ({opErr, opCode, opOffset} !== 10'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_fields: got %h expected 0", {opErr, opCode, opOffset});
    end
    checkCount++;
    if ((statIllegal !== 16'd0) || (statWaitCyc !== 16'd0)) begin
      errorCount++;
      $display("[TB] FAIL reset_stats: got %h/%h expected 0/0", statIllegal, statWaitCyc);
    end
  endtask

  task automatic test_decode_basic();
    applyStimulus(1'b1, 9'h045, 1'b1, 1'b0);
    modelStep();
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    checkCount++;
    if ((opValid !== 1'b1) || (opCode !== OPCODEATYPE_WRITE) || (opOffset !== 6'd5) || (opErr !== 1'b0)) begin
      errorCount++;
      $display("[TB] FAIL decode_write5: got v=%b c=%0d o=%0d e=%b expected v=1 c=1 o=5 e=0",
               opValid, opCode, opOffset, opErr);
    end
    modelStep();
    checkCount++;
    if (opValid !== 1'b0) begin errorCount++; $display("[TB] FAIL decode_drained: got %b expected 0", opValid); end
  endtask

  task automatic test_back_to_back();
    opcodeTagT  tags [4] = '{9'h000, 9'h0C0, 9'h100, 9'h13F};
    opcodeEnumT codes[4] = '{OPCODEATYPE_READ, OPCODEATYPE_EVICT, OPCODEATYPE_TRIM, OPCODEATYPE_TRIM};
    logic [5:0] offs [4] = '{6'd0, 6'd0, 6'd0, 6'd63};
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) applyStimulus(1'b1, tags[i], 1'b1, 1'b0);
      else       applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
      if (i > 0) begin
        checkCount++;
        if ((opValid !== 1'b1) || (opCode !== codes[i-1]) || (opOffset !== offs[i-1]) || (opErr !== 1'b0)) begin
          errorCount++;
          $display("[TB] FAIL b2b_%0d: got v=%b c=%0d o=%0d e=%b expected v=1 c=%0d o=%0d e=0",
                   i - 1, opValid, opCode, opOffset, opErr, codes[i-1], offs[i-1]);
        end
      end
      modelStep();
    end
  endtask

  task automatic test_illegal();
    opcodeTagT  tags [2] = '{9'h140, 9'h1FF};
    logic [5:0] offs [2] = '{6'd0, 6'd63};
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b1);
    modelStep();
    for (int i = 0; i <= 2; i++) begin
      if (i < 2) applyStimulus(1'b1, tags[i], 1'b1, 1'b0);
      else       applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
      if (i > 0) begin
        checkCount++;
        if ((opValid !== 1'b1) || (opCode !== OPCODEATYPE_READ) || (opOffset !== offs[i-1]) || (opErr !== 1'b1)) begin
          errorCount++;
          $display("[TB] FAIL illegal_%0d: got v=%b c=%0d o=%0d e=%b expected v=1 c=0 o=%0d e=1",
                   i - 1, opValid, opCode, opOffset, opErr, offs[i-1]);
        end
      end
      modelStep();
    end
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    checkCount++;
`ifdef MIXED_OPCODE_DECODE_STATS_EN
    if (statIllegal !== 16'd2) begin errorCount++; $display("[TB] FAIL stat_illegal: got %0d expected 2", statIllegal); end
`else
    if (statIllegal !== 16'd0) begin errorCount++; $display("[TB] FAIL stat_illegal: got %0d expected 0", statIllegal); end
`endif
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b1);
    modelStep();
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    checkCount++;
    if (statIllegal !== 16'd0) begin errorCount++; $display("[TB] FAIL stat_clr: got %0d expected 0", statIllegal); end
  endtask

  task automatic test_backpressure();
    applyStimulus(1'b1, 9'h041, 1'b0, 1'b0);
    checkCount++;
    if (tagReady !== 1'b1) begin errorCount++; $display("[TB] FAIL bp_ready0: got %b expected 1", tagReady); end
    modelStep();
    applyStimulus(1'b1, 9'h0C2, 1'b0, 1'b0);
    checkCount++;
    if ((tagReady !== 1'b1) || (opValid !== 1'b1)) begin
      errorCount++;
      $display("[TB] FAIL bp_second: got r=%b v=%b expected r=1 v=1", tagReady, opValid);
    end
    modelStep();
    applyStimulus(1'b1, 9'h103, 1'b0, 1'b0);
    checkCount++;
    if ((tagReady !== 1'b0) || (opValid !== 1'b1) || (opCode !== OPCODEATYPE_WRITE) || (opOffset !== 6'd1)) begin
      errorCount++;
      $display("[TB] FAIL bp_full: got r=%b v=%b c=%0d o=%0d expected r=0 v=1 c=1 o=1",
               tagReady, opValid, opCode, opOffset);
    end
    modelStep();
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    checkCount++;
    if ((tagReady !== 1'b0) || (opValid !== 1'b1) || (opCode !== OPCODEATYPE_WRITE) || (opOffset !== 6'd1)) begin
      errorCount++;
      $display("[TB] FAIL bp_hold_stable: got r=%b v=%b c=%0d o=%0d expected r=0 v=1 c=1 o=1",
               tagReady, opValid, opCode, opOffset);
    end
    modelStep();
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    checkCount++;
    if ((tagReady !== 1'b1) || (opValid !== 1'b1) || (opCode !== OPCODEATYPE_EVICT) || (opOffset !== 6'd2)) begin
      errorCount++;
      $display("[TB] FAIL bp_drain2: got r=%b v=%b c=%0d o=%0d expected r=1 v=1 c=3 o=2",
               tagReady, opValid, opCode, opOffset);
    end
    modelStep();
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    checkCount++;
    if (opValid !== 1'b0) begin errorCount++; $display("[TB] FAIL bp_empty: got %b expected 0", opValid); end
  endtask

  task automatic test_wait();
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b1);
    modelStep();
    applyStimulus(1'b1, 9'h083, 1'b1, 1'b0);
    modelStep();
    applyStimulus(1'b1, 9'h041, 1'b1, 1'b0);
    checkCount++;
    if ((opValid !== 1'b1) || (opCode !== OPCODEATYPE_WAIT) || (opOffset !== 6'd3)) begin
      errorCount++;
      $display("[TB] FAIL wait_present: got v=%b c=%0d o=%0d expected v=1 c=2 o=3", opValid, opCode, opOffset);
    end
    modelStep();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
      checkCount++;
      if (opValid !== 1'b0) begin errorCount++; $display("[TB] FAIL wait_hold_%0d: got %b expected 0", i, opValid); end
      modelStep();
    end
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    checkCount++;
    if ((opValid !== 1'b1) || (opCode !== OPCODEATYPE_WRITE) || (opOffset !== 6'd1)) begin
      errorCount++;
      $display("[TB] FAIL wait_release: got v=%b c=%0d o=%0d expected v=1 c=1 o=1", opValid, opCode, opOffset);
    end
    checkCount++;
    if (statWaitCyc !== 16'(expWait())) begin
      errorCount++;
      $display("[TB] FAIL stat_wait_cyc: got %0d expected %0d", statWaitCyc, expWait());
    end
    modelStep();
    applyStimulus(1'b1, 9'h080, 1'b1, 1'b0);
    modelStep();
    applyStimulus(1'b1, 9'h042, 1'b1, 1'b0);
    checkCount++;
    if ((opValid !== 1'b1) || (opCode !== OPCODEATYPE_WAIT) || (opOffset !== 6'd0)) begin
      errorCount++;
      $display("[TB] FAIL wait0_present: got v=%b c=%0d o=%0d expected v=1 c=2 o=0", opValid, opCode, opOffset);
    end
    modelStep();
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    checkCount++;
    if ((opValid !== 1'b1) || (opCode !== OPCODEATYPE_WRITE) || (opOffset !== 6'd2)) begin
      errorCount++;
      $display("[TB] FAIL wait0_nohold: got v=%b c=%0d o=%0d expected v=1 c=1 o=2", opValid, opCode, opOffset);
    end
    modelStep();
  endtask

  task automatic test_reset_mid_hold();
    applyStimulus(1'b1, 9'h085, 1'b1, 1'b0);
    modelStep();
    applyStimulus(1'b1, 9'h001, 1'b1, 1'b0);
    modelStep();
    applyStimulus(1'b1, 9'h002, 1'b1, 1'b0);
    modelStep();
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    checkCount++;
    if ((opValid !== 1'b0) || (tagReady !== 1'b0)) begin
      errorCount++;
      $display("[TB] FAIL hold_full: got v=%b r=%b expected v=0 r=0", opValid, tagReady);
    end
    rst = 1'b1;
    modelStep();
    rst = 1'b0;
    applyStimulus(1'b1, 9'h0C7, 1'b1, 1'b0);
    checkCount++;
    if ((opValid !== 1'b0) || (tagReady !== 1'b1)) begin
      errorCount++;
      $display("[TB] FAIL midreset: got v=%b r=%b expected v=0 r=1", opValid, tagReady);
    end
    modelStep();
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
    checkCount++;
    if ((opValid !== 1'b1) || (opCode !== OPCODEATYPE_EVICT) || (opOffset !== 6'd7) || (opErr !== 1'b0)) begin
      errorCount++;
      $display("[TB] FAIL midreset_push: got v=%b c=%0d o=%0d e=%b expected v=1 c=3 o=7 e=0",
               opValid, opCode, opOffset, opErr);
    end
    modelStep();
  endtask

  task automatic test_random();
    bit         tv;
    bit         ordy;
    bit         sc;
    opcodeTagT  t;
    opcodeTagT  h;
    logic [2:0] eCode;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst  = ($urandom_range(0, 199) == 0);
      tv   = ($urandom_range(0, 3) != 0);
      t    = opcodeTagT'($urandom_range(0, 511));
      if (t[8:6] == 3'd2) t[5:0] = 6'($urandom_range(0, 6));
      ordy = ($urandom_range(0, 3) != 0);
      sc   = ($urandom_range(0, 31) == 0);
      applyStimulus(tv, t, ordy, sc);
      checkCount++;
      if (tagReady !== (mq.size() < 2)) begin
        errorCount++;
        $display("[TB] FAIL rnd_tag_ready@%0d: got %b expected %b", cyc, tagReady, (mq.size() < 2));
      end
      checkCount++;
      if (opValid !== expValid()) begin
        errorCount++;
        $display("[TB] FAIL rnd_op_valid@%0d: got %b expected %b", cyc, opValid, expValid());
      end
      if (expValid()) begin
        h     = mq[0];
        eCode = (int'(h) >= 320) ? 3'd0 : 3'(int'(h) / 64);
        checkCount++;
        if ((opCode !== eCode) || (opOffset !== 6'(int'(h) % 64)) || (opErr !== (int'(h) >= 320))) begin
          errorCount++;
          $display("[TB] FAIL rnd_fields@%0d: got c=%0d o=%0d e=%b expected tag %h", cyc, opCode, opOffset, opErr, h);
        end
      end
      checkCount++;
      if ((statIllegal !== 16'(expIll())) || (statWaitCyc !== 16'(expWait()))) begin
        errorCount++;
        $display("[TB] FAIL rnd_stats@%0d: got %0d/%0d expected %0d/%0d",
                 cyc, statIllegal, statWaitCyc, expIll(), expWait());
      end
      modelStep();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    tagValid = 1'b0;
    tagIn    = '0;
    opReady  = 1'b0;
    statClr  = 1'b0;
    @(negedge clk);
    test_reset();
    test_decode_basic();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_wait();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
